// File: rtl/mac_operand_sequencer.sv
// Operand packer and result capture for the pipelined MAC: gathers NUM_INPUTS
// (pixel, weight) pairs, runs the MAC, waits out the multiplier drain, and hands the sum downstream.
module mac_operand_sequencer #(
  parameter int NUM_INPUTS   = 4,
  parameter int PIXEL_WIDTH  = 10,
  parameter int WEIGHT_WIDTH = 19,
  parameter int OUTPUT_WIDTH = 26,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [PIXEL_WIDTH-1:0]             in_pixel,
  input  logic [WEIGHT_WIDTH-1:0]            in_weight,
  output logic [NUM_INPUTS*PIXEL_WIDTH-1:0]  mac_pixels,
  output logic [NUM_INPUTS*WEIGHT_WIDTH-1:0] mac_weights,
  output logic                               mac_rst,
  input  logic                               mac_done,
  input  logic [OUTPUT_WIDTH-1:0]            mac_out,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [OUTPUT_WIDTH-1:0]            res_data
);

  localparam int CW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] FILL_LAST  = CW'(NUM_INPUTS - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  // state | meaning
  // FILL  | accepting pairs into operand slots, MAC held in reset
  // RUN   | MAC stepping through slots, waiting for mac_done
  // DRAIN | multiplier pipeline flushing into the accumulator
  // HOLD  | captured sum offered downstream, MAC back in reset
  typedef enum logic [1:0] {S_FILL, S_RUN, S_DRAIN, S_HOLD} state_t;

  state_t                               r_state;
  state_t                               w_next_state;
  logic [CW-1:0]                        r_fill_cnt;
  logic [DW-1:0]                        r_drain_cnt;
  logic [NUM_INPUTS*PIXEL_WIDTH-1:0]    r_pixels;
  logic [NUM_INPUTS*WEIGHT_WIDTH-1:0]   r_weights;
  logic [OUTPUT_WIDTH-1:0]              r_res_data;
  logic                                 r_res_valid;
  logic                                 r_in_ready;
  logic                                 r_mac_rst;

  logic w_accept;
  logic w_fill_last;
  logic w_drain_last;
  logic w_capture;
  logic w_res_hs;

  assign w_accept     = in_valid & r_in_ready;
  assign w_fill_last  = (r_fill_cnt == FILL_LAST);
  assign w_drain_last = (r_drain_cnt == DRAIN_LAST);
  assign w_res_hs     = r_res_valid & res_ready;

  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    case (r_state)
      S_FILL: begin
        if (w_accept && w_fill_last) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (mac_done) begin
          if (DRAIN_CYCLES == 0) begin
            w_next_state = S_HOLD;
            w_capture    = 1'b1;
          end else begin
            w_next_state = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (w_drain_last) begin
          w_next_state = S_HOLD;
          w_capture    = 1'b1;
        end
      end
      S_HOLD: begin
        if (w_res_hs) w_next_state = S_FILL;
      end
      default: w_next_state = S_FILL;
    endcase
  end

  // Handshake and MAC-reset outputs are registered from the next state so
  // nothing on an input reaches an output combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_FILL;
      r_in_ready <= 1'b0;
      r_mac_rst  <= 1'b1;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state == S_FILL);
      r_mac_rst  <= (w_next_state == S_FILL) || (w_next_state == S_HOLD);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fill_cnt <= '0;
      r_pixels   <= '0;
      r_weights  <= '0;
    end else if (w_accept) begin
      r_pixels[int'(r_fill_cnt)*PIXEL_WIDTH +: PIXEL_WIDTH]    <= in_pixel;
      r_weights[int'(r_fill_cnt)*WEIGHT_WIDTH +: WEIGHT_WIDTH] <= in_weight;
      r_fill_cnt <= w_fill_last ? '0 : r_fill_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_drain_cnt <= '0;
    end else if (r_state == S_DRAIN) begin
      r_drain_cnt <= w_drain_last ? '0 : r_drain_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_data  <= '0;
      r_res_valid <= 1'b0;
    end else if (w_capture) begin
      r_res_data  <= mac_out;
      r_res_valid <= 1'b1;
    end else if (w_res_hs) begin
      r_res_valid <= 1'b0;
    end
  end

  assign in_ready    = r_in_ready;
  assign mac_rst     = r_mac_rst;
  assign mac_pixels  = r_pixels;
  assign mac_weights = r_weights;
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Bench for mac_operand_sequencer: behavioural MAC with a 2-cycle multiplier,
// golden dot-product model, and a queue-based scoreboard monitor.
module tb_mac_operand_sequencer;
  localparam int N  = 4;
  localparam int PW = 10;
  localparam int WW = 19;
  localparam int OW = 26;
  localparam int DC = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PW-1:0]     in_pixel = '0;
  logic [WW-1:0]     in_weight = '0;
  logic [N*PW-1:0]   mac_pixels;
  logic [N*WW-1:0]   mac_weights;
  logic              mac_rst;
  logic              mac_done;
  logic [OW-1:0]     mac_out;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [OW-1:0]     res_data;

  mac_operand_sequencer #(
    .NUM_INPUTS(N), .PIXEL_WIDTH(PW), .WEIGHT_WIDTH(WW),
    .OUTPUT_WIDTH(OW), .DRAIN_CYCLES(DC)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pixel(in_pixel), .in_weight(in_weight),
    .mac_pixels(mac_pixels), .mac_weights(mac_weights), .mac_rst(mac_rst),
    .mac_done(mac_done), .mac_out(mac_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [OW-1:0] prod(input logic [PW-1:0] p, input logic [WW-1:0] w);
    longint v;
    v = longint'($signed(p)) * longint'($signed(w));
    return v[OW-1:0];
  endfunction

  // Reference MAC: step k uses slot k in RUN cycle k; its product lands in the
  // accumulator two cycles later; done rises in cycle N.
  logic [OW-1:0] mac_acc = '0;
  logic [OW-1:0] mpipe0 = '0;
  logic [OW-1:0] mpipe1 = '0;
  int            mac_cnt = 0;
  int            mk;
  logic          done_force = 1'b0;

  always @(posedge clk) begin
    if (mac_rst) begin
      mac_cnt <= 0;
      mac_acc <= '0;
      mpipe0  <= '0;
      mpipe1  <= '0;
    end else begin
      mk = (mac_cnt < N) ? mac_cnt : 0;
      mac_acc <= mac_acc + mpipe1;
      mpipe1  <= mpipe0;
      mpipe0  <= (mac_cnt < N) ? prod(mac_pixels[mk*PW +: PW], mac_weights[mk*WW +: WW]) : '0;
      mac_cnt <= mac_cnt + 1;
    end
  end
  assign mac_done = (mac_cnt >= N) || done_force;
  assign mac_out  = mac_acc;

  function automatic logic [OW-1:0] golden(input logic [PW-1:0] p [N], input logic [WW-1:0] w [N]);
    longint s;
    s = 0;
    for (int i = 0; i < N; i++) s += longint'($signed(p[i])) * longint'($signed(w[i]));
    return s[OW-1:0];
  endfunction

  logic [OW-1:0]   res_q [$];
  logic [N*PW-1:0] pix_q [$];
  logic [N*WW-1:0] wt_q  [$];

  // Monitor: compares DUT activity against the queued expectations.
  logic          prev_mac_rst = 1'b1;
  logic          prev_rv = 1'b0;
  logic          prev_hs = 1'b0;
  logic [OW-1:0] prev_rd = '0;
  int            run_start = 0;
  int            acc_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_mac_rst = 1'b1;
      prev_rv      = 1'b0;
      prev_hs      = 1'b0;
      acc_cnt      = 0;
    end else begin
      if (prev_mac_rst && !mac_rst) begin
        run_start = cyc;
        check("accepts_before_run", acc_cnt, N);
        acc_cnt = 0;
        if (pix_q.size() == 0) check("unexpected_run", 1, 0);
        else begin
          check("pixel_bus", mac_pixels, pix_q.pop_front());
          check("weight_bus", mac_weights, wt_q.pop_front());
        end
      end
      if (in_valid && in_ready) acc_cnt++;
      if (!mac_rst) check("in_ready_while_running", in_ready, 0);
      if (res_valid && !prev_rv) check("result_latency", cyc - run_start, N + DC + 1);
      if (res_valid && prev_rv) check("res_data_stable", res_data, prev_rd);
      if (res_valid) check("in_ready_in_hold", in_ready, 0);
      if (prev_hs) begin
        check("res_valid_drop", res_valid, 0);
        check("in_ready_after_hs", in_ready, 1);
      end
      if (res_valid && res_ready) begin
        if (res_q.size() == 0) check("unexpected_result", 1, 0);
        else check("res_data", res_data, res_q.pop_front());
      end
      prev_hs      = res_valid && res_ready;
      prev_rv      = res_valid;
      prev_rd      = res_data;
      prev_mac_rst = mac_rst;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [PW-1:0] p, input logic [WW-1:0] w);
    int t;
    t = 0;
    in_valid  = 1'b1;
    in_pixel  = p;
    in_weight = w;
    while (!in_ready && t < 300) begin
      tick();
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_set(input logic [PW-1:0] p [N], input logic [WW-1:0] w [N],
                          input logic [OW-1:0] req, input int gaps [N]);
    logic [N*PW-1:0] bp;
    logic [N*WW-1:0] bw;
    for (int i = 0; i < N; i++) begin
      bp[i*PW +: PW] = p[i];
      bw[i*WW +: WW] = w[i];
    end
    pix_q.push_back(bp);
    wt_q.push_back(bw);
    res_q.push_back(req);
    for (int i = 0; i < N; i++) begin
      send_pair(p[i], w[i]);
      repeat (gaps[i]) tick();
    end
  endtask

  task automatic wait_results();
    int t;
    t = 0;
    while (res_q.size() != 0 && t < 400) begin
      tick();
      t++;
    end
    if (res_q.size() != 0) check("result_timeout", res_q.size(), 0);
    tick();
  endtask

  logic [PW-1:0] sp [N];
  logic [WW-1:0] sw [N];
  int            sg [N];
  logic          rand_done = 1'b0;

  task automatic rand_set(input bit with_gaps);
    for (int i = 0; i < N; i++) begin
      sp[i] = PW'($urandom);
      sw[i] = WW'($urandom);
      sg[i] = with_gaps ? $urandom_range(0, 3) : 0;
    end
    send_set(sp, sw, golden(sp, sw), sg);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    #1 rst = 1'b0;
    tick(); tick();
    check("rst_res_valid", res_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_mac_rst", mac_rst, 1);
    check("rst_mac_pixels", mac_pixels, 0);
    check("rst_mac_weights", mac_weights, 0);
    check("rst_res_data", res_data, 0);
    rst = 1'b1;
    tick(); tick();

    // basic dot product: 1+2+3+4 times 0.5
    for (int i = 0; i < N; i++) begin
      sp[i] = PW'(i + 1);
      sw[i] = 19'h20000;
      sg[i] = 0;
    end
    send_set(sp, sw, 26'h140000, sg);
    wait_results();

    // signed: -3 * -0.5 in slot 0
    sp[0] = 10'h3FD; sw[0] = 19'h60000;
    for (int i = 1; i < N; i++) begin
      sp[i] = '0;
      sw[i] = '0;
    end
    send_set(sp, sw, 26'h060000, sg);
    wait_results();

    // mac_done held high while filling must be ignored
    done_force = 1'b1;
    repeat (5) tick();
    check("done_ignored_in_ready", in_ready, 1);
    check("done_ignored_mac_rst", mac_rst, 1);
    done_force = 1'b0;
    tick();

    // input gaps: valid pattern 1,0,0,1,1,0,1
    for (int i = 0; i < N; i++) begin
      sp[i] = PW'(i + 5);
      sw[i] = WW'($urandom);
    end
    sg[0] = 2; sg[1] = 0; sg[2] = 1; sg[3] = 0;
    send_set(sp, sw, golden(sp, sw), sg);
    wait_results();

    // backpressure: hold res_ready low for 10 cycles with a result pending
    res_ready = 1'b0;
    rand_set(1'b0);
    t = 0;
    while (!res_valid && t < 100) begin
      tick();
      t++;
    end
    check("backpressure_res_valid", res_valid, 1);
    repeat (10) tick();
    check("backpressure_in_ready", in_ready, 0);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tick();
    check("post_hs_in_ready", in_ready, 1);
    res_ready = 1'b1;
    wait_results();

    // back-to-back sets
    rand_set(1'b0);
    rand_set(1'b0);
    wait_results();

    // reset asserted during DRAIN
    rand_set(1'b0);
    t = 0;
    while (!mac_done && t < 100) begin
      tick();
      t++;
    end
    check("mac_done_seen", mac_done, 1);
    tick();
    rst = 1'b0;
    #1;
    check("abort_res_valid", res_valid, 0);
    check("abort_mac_rst", mac_rst, 1);
    check("abort_in_ready", in_ready, 0);
    if (res_q.size() != 0) void'(res_q.pop_back());
    tick();
    check("abort_mac_pixels", mac_pixels, 0);
    rst = 1'b1;
    tick();
    rand_set(1'b0);
    wait_results();

    // randomized sets with gaps and random downstream readiness
    fork
      begin
        for (int s = 0; s < 20; s++) rand_set(1'b1);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          tick();
          res_ready = 1'($urandom_range(0, 1));
        end
        res_ready = 1'b1;
      end
    join
    wait_results();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
